decode_stage: RTL and testbench

- Decode stage sitting directly downstream of the instruction fetch bank in the proctypes pipeline.
- Consumes the fetch handshake (valid, pc, 16-bit inst) and drives the fetch action (dequeue/stall) back to it.
- Assembles 1- or 2-parcel instructions, splits fields and sign-extends immediates.
- Holds the result in a single output register for the execute stage, using a valid/ready handshake.

---
 rtl/proctypes_pkg.sv | 34 +++
 rtl/decode_stage_if.sv | 37 +++
 rtl/decode_fields.sv | 25 ++
 rtl/decode_stage.sv | 120 ++++++++++++
 tb/tb_decode_stage.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proctypes_pkg.sv
// Shared pipeline types for the proctypes core: fetch handshake types plus
// the decode-stage instruction record, state enum and long-op helper.
package proctypes;

  typedef logic [31:0] InstructionAddr;
  typedef logic [15:0] Instruction;

  typedef enum logic {
    fetchStall   = 1'b0,
    fetchDequeue = 1'b1
  } FetchAction;

  typedef enum logic {
    S_FIRST = 1'b0,
    S_EXT   = 1'b1
  } DecodeState;

  localparam logic [3:0] LONG_OP_MIN = 4'hC;

  typedef struct packed {
    InstructionAddr pc;
    logic [3:0]     op;
    logic [3:0]     rd;
    logic [3:0]     rs1;
    logic [3:0]     rs2;
    logic [31:0]    imm;
    logic           is_long;
  } DecodedInst;

  function automatic logic is_long_op(input logic [3:0] op);
    return op >= LONG_OP_MIN;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side signals of the decode stage.
// Handshakes: fetch parcel moves when fetch_action==fetchDequeue; dec_* moves when dec_valid && ex_ready.
interface decode_stage_if;
  import proctypes::*;

  logic           fetch_valid;
  InstructionAddr fetch_pc;
  Instruction     fetch_inst;
  FetchAction     fetch_action;
  logic           flush;
  logic           ex_ready;
  logic           dec_valid;
  InstructionAddr dec_pc;
  logic [3:0]     dec_op;
  logic [3:0]     dec_rd;
  logic [3:0]     dec_rs1;
  logic [3:0]     dec_rs2;
  logic [31:0]    dec_imm;
  logic           dec_long;
  logic           dec_err;
  logic [31:0]    perf_decoded;
  logic [31:0]    perf_stall;

  // master: the decode stage itself; slave: the surrounding pipeline.
  modport master (
    input  fetch_valid, fetch_pc, fetch_inst, flush, ex_ready,
    output fetch_action, dec_valid, dec_pc, dec_op, dec_rd, dec_rs1, dec_rs2,
           dec_imm, dec_long, dec_err, perf_decoded, perf_stall
  );

  modport slave (
    output fetch_valid, fetch_pc, fetch_inst, flush, ex_ready,
    input  fetch_action, dec_valid, dec_pc, dec_op, dec_rd, dec_rs1, dec_rs2,
           dec_imm, dec_long, dec_err, perf_decoded, perf_stall
  );

endinterface

// File: rtl/decode_fields.sv
// Combinational split of a parcel into register fields and a sign-extended
// immediate (imm4 for short instructions, the extension parcel for long ones).
module decode_fields
  import proctypes::*;
(
  input  Instruction     parcel,
  input  Instruction     ext_parcel,
  input  InstructionAddr pc,
  input  logic           is_long,
  output DecodedInst     fields
);

  always_comb begin
    fields         = '0;
    fields.pc      = pc;
    fields.op      = parcel[15:12];
    fields.rd      = parcel[11:8];
    fields.rs1     = parcel[7:4];
    fields.rs2     = parcel[3:0];
    fields.imm     = is_long ? {{16{ext_parcel[15]}}, ext_parcel}
                             : {{28{parcel[3]}}, parcel[3:0]};
    fields.is_long = is_long;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: assembles 1- or 2-parcel instructions from the fetch bank into
// a single output register. Perf counters exist only with DECODE_PERF_EN defined.
module decode_stage
  import proctypes::*;
#(
  parameter int unsigned PC_STEP = 2
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.master bus,
  output DecodeState     state_dbg
);

  DecodeState     state;
  Instruction     hold_inst;
  InstructionAddr hold_pc;
  DecodedInst     out_q;
  logic           dec_valid_q;
  logic           dec_err_q;

  logic       slot_free;
  logic       accept;
  logic       pc_ok;
  logic       load;
  logic       in_ext;
  DecodedInst fields;

  assign in_ext    = (state == S_EXT);
  assign slot_free = !dec_valid_q || bus.ex_ready;
  assign accept    = bus.fetch_valid && slot_free && !bus.flush && !rst;
  assign pc_ok     = (bus.fetch_pc == hold_pc + 32'(PC_STEP));

  // In S_EXT the held first parcel supplies fields; the live parcel is imm16.
  assign load = accept && (in_ext ? pc_ok : !is_long_op(bus.fetch_inst[15:12]));

  decode_fields u_fields (
    .parcel     (in_ext ? hold_inst : bus.fetch_inst),
    .ext_parcel (bus.fetch_inst),
    .pc         (in_ext ? hold_pc : bus.fetch_pc),
    .is_long    (in_ext),
    .fields     (fields)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FIRST;
      hold_inst   <= '0;
      hold_pc     <= '0;
      out_q       <= '0;
      dec_valid_q <= 1'b0;
      dec_err_q   <= 1'b0;
    end else if (bus.flush) begin
      state       <= S_FIRST;
      dec_valid_q <= 1'b0;
      dec_err_q   <= 1'b0;
    end else begin
      dec_err_q <= 1'b0;
      if (load) begin
        out_q       <= fields;
        dec_valid_q <= 1'b1;
      end else if (bus.ex_ready) begin
        dec_valid_q <= 1'b0;
      end
      case (state)
        S_FIRST: begin
          if (accept && is_long_op(bus.fetch_inst[15:12])) begin
            hold_inst <= bus.fetch_inst;
            hold_pc   <= bus.fetch_pc;
            state     <= S_EXT;
          end
        end
        S_EXT: begin
          if (accept) begin
            state     <= S_FIRST;
            dec_err_q <= !pc_ok;
          end
        end
        default: state <= S_FIRST;
      endcase
    end
  end

  assign bus.fetch_action = accept ? fetchDequeue : fetchStall;
  assign bus.dec_valid    = dec_valid_q;
  assign bus.dec_pc       = out_q.pc;
  assign bus.dec_op       = out_q.op;
  assign bus.dec_rd       = out_q.rd;
  assign bus.dec_rs1      = out_q.rs1;
  assign bus.dec_rs2      = out_q.rs2;
  assign bus.dec_imm      = out_q.imm;
  assign bus.dec_long     = out_q.is_long;
  assign bus.dec_err      = dec_err_q;
  assign state_dbg        = state;

`ifdef DECODE_PERF_EN
  logic [31:0] perf_decoded_q;
  logic [31:0] perf_stall_q;
  logic        stall_cycle;

  assign stall_cycle = (bus.fetch_valid && dec_valid_q && !bus.ex_ready) ||
                       (in_ext && !bus.fetch_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_decoded_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (load)        perf_decoded_q <= perf_decoded_q + 32'd1;
      if (stall_cycle) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_decoded = perf_decoded_q;
  assign bus.perf_stall   = perf_stall_q;
`else
  assign bus.perf_decoded = 32'd0;
  assign bus.perf_stall   = 32'd0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized parcel stream
// checked against a stream-level reference model and an expected-output queue.
module tb_decode_stage;
  import proctypes::*;

  localparam int W = 81;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  DecodeState state_dbg;

  decode_stage_if dif ();

  decode_stage #(.PC_STEP(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (dif.master),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  // Observations taken at the falling edge by tick.
  FetchAction   obs_action;
  logic         obs_valid;
  logic [W-1:0] obs_pkt;
  logic         obs_err;
  logic [31:0]  obs_perf_dec;
  logic [31:0]  obs_perf_stall;
  DecodeState   obs_state;

  // Reference model: stream-level view of what the stage should be doing.
  logic        m_full = 1'b0;
  logic        mid_long = 1'b0;
  logic [31:0] mid_pc = '0;
  logic [15:0] mid_inst = '0;
  logic [31:0] exp_dec = '0;
  logic [31:0] exp_stall = '0;
  logic        exp_action_now;
  logic        exp_valid_now;
  logic [31:0] snap_dec;
  logic [31:0] snap_stall;

  function automatic logic [W-1:0] model_short(input logic [31:0] pc, input logic [15:0] p);
    int v;
    v = int'(p[3:0]);
    if (v >= 8) v = v - 16;
    return {pc, p[15:12], p[11:8], p[7:4], p[3:0], 32'(v), 1'b0};
  endfunction

  function automatic logic [W-1:0] model_long(input logic [31:0] pc, input logic [15:0] p,
                                              input logic [15:0] e);
    int v;
    v = int'(e);
    if (v >= 32768) v = v - 65536;
    return {pc, p[15:12], p[11:8], p[7:4], p[3:0], 32'(v), 1'b1};
  endfunction

  task automatic tick;
    logic acc;
    logic load;
    @(negedge clk);
    obs_action     = dif.fetch_action;
    obs_valid      = dif.dec_valid;
    obs_pkt        = {dif.dec_pc, dif.dec_op, dif.dec_rd, dif.dec_rs1, dif.dec_rs2,
                      dif.dec_imm, dif.dec_long};
    obs_err        = dif.dec_err;
    obs_perf_dec   = dif.perf_decoded;
    obs_perf_stall = dif.perf_stall;
    obs_state      = state_dbg;
    snap_dec       = exp_dec;
    snap_stall     = exp_stall;
    exp_valid_now  = m_full;
    acc = dif.fetch_valid && (!m_full || dif.ex_ready) && !dif.flush && !rst;
    exp_action_now = acc;
    load = 1'b0;
    if (rst) begin
      m_full = 1'b0; mid_long = 1'b0; exp_dec = '0; exp_stall = '0;
    end else begin
      if ((dif.fetch_valid && m_full && !dif.ex_ready) || (mid_long && !dif.fetch_valid))
        exp_stall = exp_stall + 32'd1;
      if (dif.flush) begin
        m_full = 1'b0; mid_long = 1'b0;
      end else begin
        if (acc) begin
          if (mid_long) begin
            mid_long = 1'b0;
            load = (dif.fetch_pc == mid_pc + 32'd2);
          end else if (dif.fetch_inst[15:12] >= 4'd12) begin
            mid_long = 1'b1; mid_pc = dif.fetch_pc; mid_inst = dif.fetch_inst;
          end else begin
            load = 1'b1;
          end
        end
        if (load) begin
          m_full = 1'b1; exp_dec = exp_dec + 32'd1;
        end else if (dif.ex_ready) begin
          m_full = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [15:0] p);
    dif.fetch_valid = 1'b1;
    dif.fetch_pc    = pc;
    dif.fetch_inst  = p;
  endtask

  task automatic test_reset;
    rst = 1'b1; dif.flush = 1'b0; dif.ex_ready = 1'b1;
    present(32'd0, 16'h1234);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks += 3;
      if (obs_action !== fetchStall) begin
        n_fail++; $display("FAIL reset_action: got %0d expected %0d", obs_action, fetchStall);
      end
      if (obs_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_valid: got %b expected 0", obs_valid);
      end
      if (obs_pkt !== '0 || obs_err !== 1'b0) begin
        n_fail++; $display("FAIL reset_fields: got %h err %b expected 0", obs_pkt, obs_err);
      end
    end
    n_checks++;
    if (obs_perf_dec !== 32'd0 || obs_perf_stall !== 32'd0) begin
      n_fail++; $display("FAIL reset_perf: got %h/%h expected 0/0", obs_perf_dec, obs_perf_stall);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (obs_action !== fetchDequeue) begin
      n_fail++; $display("FAIL reset_first_accept: got %0d expected %0d", obs_action, fetchDequeue);
    end
    dif.fetch_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_short_stream;
    dif.ex_ready = 1'b1;
    present(32'd0, 16'h1234);
    tick();
    present(32'd2, 16'h2ABF);
    tick();
    n_checks += 2;
    if (obs_valid !== 1'b1 || obs_pkt !== model_short(32'd0, 16'h1234)) begin
      n_fail++; $display("FAIL short_first: got v=%b %h expected v=1 %h", obs_valid, obs_pkt,
                         model_short(32'd0, 16'h1234));
    end
    if (obs_action !== fetchDequeue) begin
      n_fail++; $display("FAIL short_second_deq: got %0d expected %0d", obs_action, fetchDequeue);
    end
    dif.fetch_valid = 1'b0;
    tick();
    n_checks++;
    if (obs_valid !== 1'b1 || obs_pkt !== model_short(32'd2, 16'h2ABF)) begin
      n_fail++; $display("FAIL short_second: got v=%b %h expected v=1 %h", obs_valid, obs_pkt,
                         model_short(32'd2, 16'h2ABF));
    end
    tick();
    n_checks++;
    if (obs_valid !== 1'b0) begin
      n_fail++; $display("FAIL short_drain: got %b expected 0", obs_valid);
    end
  endtask

  task automatic test_long(input logic [31:0] pc, input logic [15:0] p, input logic [15:0] e);
    dif.ex_ready = 1'b1;
    present(pc, p);
    tick();
    present(pc + 32'd2, e);
    tick();
    n_checks += 2;
    if (obs_action !== fetchDequeue) begin
      n_fail++; $display("FAIL long_ext_deq: got %0d expected %0d", obs_action, fetchDequeue);
    end
    if (obs_valid !== 1'b0) begin
      n_fail++; $display("FAIL long_early_valid: got %b expected 0", obs_valid);
    end
    dif.fetch_valid = 1'b0;
    tick();
    n_checks++;
    if (obs_valid !== 1'b1 || obs_pkt !== model_long(pc, p, e)) begin
      n_fail++; $display("FAIL long_result: got v=%b %h expected v=1 %h", obs_valid, obs_pkt,
                         model_long(pc, p, e));
    end
    tick();
  endtask

  task automatic test_backpressure;
    logic [W-1:0] held;
    dif.ex_ready = 1'b0;
    present(32'd8, 16'h3456);
    tick();
    present(32'd10, 16'h4567);
    held = model_short(32'd8, 16'h3456);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks += 2;
      if (obs_action !== fetchStall) begin
        n_fail++; $display("FAIL bp_stall: got %0d expected %0d", obs_action, fetchStall);
      end
      if (obs_valid !== 1'b1 || obs_pkt !== held) begin
        n_fail++; $display("FAIL bp_hold: got v=%b %h expected v=1 %h", obs_valid, obs_pkt, held);
      end
    end
    dif.ex_ready = 1'b1;
    tick();
    n_checks++;
    if (obs_action !== fetchDequeue) begin
      n_fail++; $display("FAIL bp_resume: got %0d expected %0d", obs_action, fetchDequeue);
    end
    dif.fetch_valid = 1'b0;
    tick();
    n_checks++;
    if (obs_valid !== 1'b1 || obs_pkt !== model_short(32'd10, 16'h4567)) begin
      n_fail++; $display("FAIL bp_next: got v=%b %h expected v=1 %h", obs_valid, obs_pkt,
                         model_short(32'd10, 16'h4567));
    end
    tick();
  endtask

  task automatic test_flush;
    dif.ex_ready = 1'b1;
    present(32'd8, 16'hD000);
    tick();
    present(32'd10, 16'h5111);
    dif.flush = 1'b1;
    tick();
    n_checks++;
    if (obs_action !== fetchStall) begin
      n_fail++; $display("FAIL flush_no_deq: got %0d expected %0d", obs_action, fetchStall);
    end
    dif.flush = 1'b0;
    tick();
    n_checks += 3;
    if (obs_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid: got %b expected 0", obs_valid);
    end
    if (obs_state !== S_FIRST) begin
      n_fail++; $display("FAIL flush_state: got %0d expected %0d", obs_state, S_FIRST);
    end
    if (obs_action !== fetchDequeue) begin
      n_fail++; $display("FAIL flush_fresh_deq: got %0d expected %0d", obs_action, fetchDequeue);
    end
    dif.fetch_valid = 1'b0;
    tick();
    n_checks++;
    if (obs_valid !== 1'b1 || obs_pkt !== model_short(32'd10, 16'h5111)) begin
      n_fail++; $display("FAIL flush_fresh: got v=%b %h expected v=1 %h", obs_valid, obs_pkt,
                         model_short(32'd10, 16'h5111));
    end
    tick();
  endtask

  task automatic test_pc_mismatch;
    dif.ex_ready = 1'b1;
    present(32'd10, 16'hC000);
    tick();
    present(32'd20, 16'h1111);
    tick();
    n_checks++;
    if (obs_action !== fetchDequeue) begin
      n_fail++; $display("FAIL err_ext_deq: got %0d expected %0d", obs_action, fetchDequeue);
    end
    dif.fetch_valid = 1'b0;
    tick();
    n_checks += 2;
    if (obs_err !== 1'b1) begin
      n_fail++; $display("FAIL err_pulse: got %b expected 1", obs_err);
    end
    if (obs_valid !== 1'b0) begin
      n_fail++; $display("FAIL err_no_valid: got %b expected 0", obs_valid);
    end
    tick();
    n_checks += 2;
    if (obs_err !== 1'b0) begin
      n_fail++; $display("FAIL err_one_cycle: got %b expected 0", obs_err);
    end
`ifdef DECODE_PERF_EN
    if (obs_perf_dec !== snap_dec) begin
      n_fail++; $display("FAIL err_perf_decoded: got %0d expected %0d", obs_perf_dec, snap_dec);
    end
`else
    if (obs_perf_dec !== 32'd0) begin
      n_fail++; $display("FAIL err_perf_decoded: got %0d expected 0", obs_perf_dec);
    end
`endif
    present(32'd22, 16'h6222);
    tick();
    dif.fetch_valid = 1'b0;
    tick();
    n_checks++;
    if (obs_valid !== 1'b1 || obs_pkt !== model_short(32'd22, 16'h6222)) begin
      n_fail++; $display("FAIL err_recover: got v=%b %h expected v=1 %h", obs_valid, obs_pkt,
                         model_short(32'd22, 16'h6222));
    end
    tick();
  endtask

  task automatic test_random;
    logic [31:0] pq_pc[$];
    logic [15:0] pq_inst[$];
    logic [31:0] pc;
    logic [15:0] p;
    logic [15:0] e;
    logic [W-1:0] want;
    int cyc;
    pc = 32'h0000_0100;
    for (int i = 0; i < 60; i++) begin
      p = 16'($urandom);
      pq_pc.push_back(pc); pq_inst.push_back(p);
      if (p[15:12] >= 4'd12) begin
        e = 16'($urandom);
        pq_pc.push_back(pc + 32'd2); pq_inst.push_back(e);
        exp_q.push_back(model_long(pc, p, e));
        pc = pc + 32'd4;
      end else begin
        exp_q.push_back(model_short(pc, p));
        pc = pc + 32'd2;
      end
    end
    cyc = 0;
    while ((pq_pc.size() > 0 || exp_q.size() > 0) && cyc < 2000) begin
      dif.fetch_valid = (pq_pc.size() > 0) && ($urandom_range(0, 3) != 0);
      if (pq_pc.size() > 0) begin
        dif.fetch_pc = pq_pc[0]; dif.fetch_inst = pq_inst[0];
      end
      dif.ex_ready = ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
      n_checks += 2;
      if (obs_action !== FetchAction'(exp_action_now)) begin
        n_fail++; $display("FAIL rand_action: got %0d expected %0d", obs_action, exp_action_now);
      end
      if (obs_valid !== exp_valid_now) begin
        n_fail++; $display("FAIL rand_valid: got %b expected %b", obs_valid, exp_valid_now);
      end
      if (exp_action_now) begin
        void'(pq_pc.pop_front()); void'(pq_inst.pop_front());
      end
      if (exp_valid_now && dif.ex_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: got %h expected none", obs_pkt);
        end else begin
          want = exp_q.pop_front();
          if (obs_pkt !== want) begin
            n_fail++; $display("FAIL rand_pkt: got %h expected %h", obs_pkt, want);
          end
        end
      end
    end
    dif.fetch_valid = 1'b0;
    n_checks++;
    if (cyc >= 2000) begin
      n_fail++; $display("FAIL rand_timeout: got %0d left expected 0", exp_q.size());
    end
    tick();
    n_checks++;
`ifdef DECODE_PERF_EN
    if (obs_perf_dec !== snap_dec || obs_perf_stall !== snap_stall) begin
      n_fail++; $display("FAIL rand_perf: got %0d/%0d expected %0d/%0d", obs_perf_dec,
                         obs_perf_stall, snap_dec, snap_stall);
    end
`else
    if (obs_perf_dec !== 32'd0 || obs_perf_stall !== 32'd0) begin
      n_fail++; $display("FAIL rand_perf: got %0d/%0d expected 0/0", obs_perf_dec, obs_perf_stall);
    end
`endif
  endtask

  initial begin
    dif.fetch_valid = 1'b0;
    dif.fetch_pc    = '0;
    dif.fetch_inst  = '0;
    dif.flush       = 1'b0;
    dif.ex_ready    = 1'b0;
    test_reset();
    test_short_stream();
    test_long(32'd4, 16'hC123, 16'h8000);
    test_long(32'hFFFF_FFFE, 16'hE9A5, 16'h7FFF);
    test_backpressure();
    test_flush();
    test_pc_mismatch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
